// File: rtl/fwd_hazard_ctrl_if.sv
// rtl/fwd_hazard_ctrl_if.sv - decode-side issue bus between decode and the forwarding/hazard controller
interface fwd_hazard_if #(
  parameter int REG_AW = 5
);
  logic              issueValid;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1Used;
  logic              rs2Used;
  logic [REG_AW-1:0] rd;
  logic              rdWrite;
  logic              divFlag;
  logic              muxSrc1;
  logic              muxSrc2;
  logic              mux2Src1;
  logic              mux2Src2;
  logic              stall;
  logic              issueAccept;
  logic              divBusy;

  // Decode side: presents the instruction, consumes selects and stall.
  modport master (
    output issueValid, rs1, rs2, rs1Used, rs2Used, rd, rdWrite, divFlag,
    input  muxSrc1, muxSrc2, mux2Src1, mux2Src2, stall, issueAccept, divBusy
  );

  // Controller side.
  modport slave (
    input  issueValid, rs1, rs2, rs1Used, rs2Used, rd, rdWrite, divFlag,
    output muxSrc1, muxSrc2, mux2Src1, mux2Src2, stall, issueAccept, divBusy
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - operand forwarding selects, decode stall and divider sequencing for the FP ALU pipe
module fwd_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int DIV_LAT = 8
) (
  input logic         Clock,
  input logic         Reset_n,
  fwd_hazard_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  // A divide of latency 1 is just an ordinary single-cycle op.
  localparam logic       DIV_MULTI = (DIV_LAT > 1);
  localparam logic [7:0] DIV_LOAD  = 8'(DIV_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        count;
  logic [7:0]        count_nxt;

  logic              ex_valid;
  logic              ex_wr;
  logic [REG_AW-1:0] ex_rd;
  logic              wb_valid;
  logic              wb_wr;
  logic [REG_AW-1:0] wb_rd;
  logic              wb2_valid;
  logic              wb2_wr;
  logic [REG_AW-1:0] wb2_rd;

  logic              ex_hit1;
  logic              ex_hit2;
  logic              wb_hit1;
  logic              wb_hit2;
  logic              wb2_hit1;
  logic              wb2_hit2;
  logic              read1;
  logic              read2;
  logic              div_busy;
  logic              stall_int;
  logic              accept;
  logic              advance;
  logic              div_start;

  // Source-vs-destination matches per stage; only valid writing slots count.
  always_comb begin
    ex_hit1  = ex_valid  & ex_wr  & (ex_rd  == bus.rs1);
    ex_hit2  = ex_valid  & ex_wr  & (ex_rd  == bus.rs2);
    wb_hit1  = wb_valid  & wb_wr  & (wb_rd  == bus.rs1);
    wb_hit2  = wb_valid  & wb_wr  & (wb_rd  == bus.rs2);
    wb2_hit1 = wb2_valid & wb2_wr & (wb2_rd == bus.rs1);
    wb2_hit2 = wb2_valid & wb2_wr & (wb2_rd == bus.rs2);
  end

  // Stall/accept and forwarding selects; the newest producer wins, EX forces a stall.
  always_comb begin
    read1     = bus.issueValid & bus.rs1Used;
    read2     = bus.issueValid & bus.rs2Used;
    div_busy  = (state == DIV) && (count != 8'd0);
    stall_int = bus.issueValid & (div_busy | (read1 & ex_hit1) | (read2 & ex_hit2));
    accept    = bus.issueValid & ~stall_int;
    advance   = (state == IDLE) || (count == 8'd0);
    div_start = accept & bus.divFlag & DIV_MULTI;

    bus.muxSrc1     = read1 & ~ex_hit1 & wb_hit1;
    bus.muxSrc2     = read2 & ~ex_hit2 & wb_hit2;
    bus.mux2Src1    = read1 & ~ex_hit1 & ~wb_hit1 & wb2_hit1;
    bus.mux2Src2    = read2 & ~ex_hit2 & ~wb_hit2 & wb2_hit2;
    bus.stall       = stall_int;
    bus.issueAccept = accept;
    bus.divBusy     = div_busy;
  end

  // Divider sequencer next state: count down while the divide sits in EX.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (div_start) begin
          state_nxt = DIV;
          count_nxt = DIV_LOAD;
        end
      end
      DIV: begin
        if (count != 8'd0) begin
          count_nxt = count - 8'd1;
        end else if (div_start) begin
          // A back-to-back divide accepted in the final cycle restarts the count.
          count_nxt = DIV_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 8'd0;
      end
    endcase
  end

  // Divider sequencer state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Pipeline slot tracking; while a divide holds EX, WB drains to WB2 and refills with a bubble.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_rd     <= '0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
      wb_rd     <= '0;
      wb2_valid <= 1'b0;
      wb2_wr    <= 1'b0;
      wb2_rd    <= '0;
    end else begin
      wb2_valid <= wb_valid;
      wb2_wr    <= wb_wr;
      wb2_rd    <= wb_rd;
      if (advance) begin
        wb_valid <= ex_valid;
        wb_wr    <= ex_wr;
        wb_rd    <= ex_rd;
        ex_valid <= accept;
        ex_wr    <= accept & bus.rdWrite;
        ex_rd    <= bus.rd;
      end else begin
        wb_valid <= 1'b0;
        wb_wr    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl with DIV_LAT 8 and 1 side by side
module tb_fwd_hazard_ctrl;

  logic       Clock;
  logic       Reset_n;
  logic       iv;
  logic       u1;
  logic       u2;
  logic       wr;
  logic       dv;
  logic [4:0] r1;
  logic [4:0] r2;
  logic [4:0] rd;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    int         t;
    int         lat;
    logic [4:0] rd;
    logic       wr;
  } rec_t;

  typedef struct {
    logic m1;
    logic m2;
    logic x1;
    logic x2;
    logic st;
    logic acc;
    logic busy;
  } exp_t;

  rec_t q8[$];
  rec_t q1[$];

  fwd_hazard_if #(.REG_AW(5)) b8 ();
  fwd_hazard_if #(.REG_AW(5)) b1 ();

  assign b8.issueValid = iv;
  assign b8.rs1        = r1;
  assign b8.rs2        = r2;
  assign b8.rs1Used    = u1;
  assign b8.rs2Used    = u2;
  assign b8.rd         = rd;
  assign b8.rdWrite    = wr;
  assign b8.divFlag    = dv;
  assign b1.issueValid = iv;
  assign b1.rs1        = r1;
  assign b1.rs2        = r2;
  assign b1.rs1Used    = u1;
  assign b1.rs2Used    = u2;
  assign b1.rd         = rd;
  assign b1.rdWrite    = wr;
  assign b1.divFlag    = dv;

  fwd_hazard_ctrl #(.REG_AW(5), .DIV_LAT(8)) dut8 (.Clock(Clock), .Reset_n(Reset_n), .bus(b8));
  fwd_hazard_ctrl #(.REG_AW(5), .DIV_LAT(1)) dut1 (.Clock(Clock), .Reset_n(Reset_n), .bus(b1));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // Timing model: an instruction accepted at t with effective latency L sits in EX for
  // t+1..t+L, WB at t+L+1, WB2 at t+L+2; a multi-cycle divide keeps the divider busy t+1..t+L-1.
  function automatic exp_t model(input int which);
    exp_t e;
    rec_t q[$];
    logic ex1, ex2, w1, w2, v1, v2, busy;
    ex1 = 0; ex2 = 0; w1 = 0; w2 = 0; v1 = 0; v2 = 0; busy = 0;
    if (which == 0) q = q8;
    else q = q1;
    foreach (q[i]) begin
      if (cyc >= q[i].t + 1 && cyc <= q[i].t + q[i].lat - 1) busy = 1;
      if (q[i].wr) begin
        if (cyc >= q[i].t + 1 && cyc <= q[i].t + q[i].lat) begin
          if (q[i].rd == r1) ex1 = 1;
          if (q[i].rd == r2) ex2 = 1;
        end
        if (cyc == q[i].t + q[i].lat + 1) begin
          if (q[i].rd == r1) w1 = 1;
          if (q[i].rd == r2) w2 = 1;
        end
        if (cyc == q[i].t + q[i].lat + 2) begin
          if (q[i].rd == r1) v1 = 1;
          if (q[i].rd == r2) v2 = 1;
        end
      end
    end
    e.busy = busy;
    e.st   = iv & (busy | (u1 & ex1) | (u2 & ex2));
    e.acc  = iv & ~e.st;
    e.m1   = iv & u1 & ~ex1 & w1;
    e.m2   = iv & u2 & ~ex2 & w2;
    e.x1   = iv & u1 & ~ex1 & ~w1 & v1;
    e.x2   = iv & u2 & ~ex2 & ~w2 & v2;
    return e;
  endfunction

  task automatic set_in(input logic v, input logic [4:0] s1, input logic s1u,
                        input logic [4:0] s2, input logic s2u,
                        input logic [4:0] d, input logic w, input logic dflag);
    iv = v; r1 = s1; u1 = s1u; r2 = s2; u2 = s2u; rd = d; wr = w; dv = dflag;
  endtask

  // Compare both DUTs against the model, then clock once and log accepted instructions.
  task automatic step();
    exp_t e8, e1;
    rec_t r;
    #1;
    e8 = model(0);
    e1 = model(1);
    chk("d8.muxSrc1",     b8.muxSrc1,     e8.m1);
    chk("d8.muxSrc2",     b8.muxSrc2,     e8.m2);
    chk("d8.mux2Src1",    b8.mux2Src1,    e8.x1);
    chk("d8.mux2Src2",    b8.mux2Src2,    e8.x2);
    chk("d8.stall",       b8.stall,       e8.st);
    chk("d8.issueAccept", b8.issueAccept, e8.acc);
    chk("d8.divBusy",     b8.divBusy,     e8.busy);
    chk("d1.muxSrc1",     b1.muxSrc1,     e1.m1);
    chk("d1.muxSrc2",     b1.muxSrc2,     e1.m2);
    chk("d1.mux2Src1",    b1.mux2Src1,    e1.x1);
    chk("d1.mux2Src2",    b1.mux2Src2,    e1.x2);
    chk("d1.stall",       b1.stall,       e1.st);
    chk("d1.issueAccept", b1.issueAccept, e1.acc);
    chk("d1.divBusy",     b1.divBusy,     e1.busy);
    @(posedge Clock);
    if (Reset_n) begin
      r.t = cyc; r.rd = rd; r.wr = wr;
      if (e8.acc) begin
        r.lat = dv ? 8 : 1;
        q8.push_back(r);
      end
      if (e1.acc) begin
        r.lat = 1;
        q1.push_back(r);
      end
    end
    while (q8.size() > 0 && q8[0].t + q8[0].lat + 2 < cyc) void'(q8.pop_front());
    while (q1.size() > 0 && q1[0].t + q1[0].lat + 2 < cyc) void'(q1.pop_front());
    cyc++;
    #1;
  endtask

  initial begin
    // Reset held with an issue request pending: only issueAccept follows issueValid.
    Reset_n = 1'b0;
    set_in(1, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
    #1;
    chk("rst.stall",   b8.stall,       1'b0);
    chk("rst.mux",     b8.muxSrc1,     1'b0);
    chk("rst.divBusy", b8.divBusy,     1'b0);
    chk("rst.accept",  b8.issueAccept, 1'b1);
    step();
    step();
    Reset_n = 1'b1;
    set_in(0, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0);
    step();
    step();

    // Back-to-back dependence on r5.
    set_in(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0);
    step();
    set_in(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
    #1;
    chk("b2b.t1.stall", b8.stall, 1'b1);
    step();
    #1;
    chk("b2b.t2.muxSrc1", b8.muxSrc1,     1'b1);
    chk("b2b.t2.accept",  b8.issueAccept, 1'b1);
    step();
    set_in(1, 5'd0, 0, 5'd5, 1, 5'd10, 1, 0);
    #1;
    chk("b2b.t3.mux2Src2", b8.mux2Src2, 1'b1);
    step();
    #1;
    chk("b2b.t4.mux2Src2", b8.mux2Src2, 1'b0);
    chk("b2b.t4.muxSrc2",  b8.muxSrc2,  1'b0);
    chk("b2b.t4.stall",    b8.stall,    1'b0);
    step();

    // Two writers of r7: the newer one in WB beats the older one in WB2.
    set_in(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0);
    step();
    step();
    set_in(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    step();
    set_in(1, 5'd7, 1, 5'd0, 0, 5'd11, 1, 0);
    #1;
    chk("prio.muxSrc1",  b8.muxSrc1,  1'b1);
    chk("prio.mux2Src1", b8.mux2Src1, 1'b0);
    step();

    // Divide rd=9, then a dependent reader of r9.
    set_in(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    step();
    for (int k = 1; k <= 7; k++) begin
      set_in(1, 5'd2, 1, 5'd0, 0, 5'd12, 1, 0);
      #1;
      chk("div.busy",  b8.divBusy, 1'b1);
      chk("div.stall", b8.stall,   1'b1);
      step();
    end
    set_in(1, 5'd9, 1, 5'd0, 0, 5'd13, 1, 0);
    #1;
    chk("div.t8.stall",   b8.stall,   1'b1);
    chk("div.t8.divBusy", b8.divBusy, 1'b0);
    step();
    #1;
    chk("div.t9.muxSrc1", b8.muxSrc1,     1'b1);
    chk("div.t9.accept",  b8.issueAccept, 1'b1);
    step();

    // Divide, then an independent reader accepted exactly at t+8.
    set_in(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    step();
    for (int k = 1; k <= 7; k++) begin
      set_in(1, 5'd2, 1, 5'd0, 0, 5'd14, 1, 0);
      step();
    end
    #1;
    chk("div2.t8.accept", b8.issueAccept, 1'b1);
    step();
    set_in(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    step();
    step();

    // Asynchronous reset in the middle of a divide.
    set_in(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
    step();
    set_in(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    step();
    step();
    #1;
    chk("arst.pre.divBusy", b8.divBusy, 1'b1);
    #1;
    Reset_n = 1'b0;
    q8.delete();
    q1.delete();
    #1;
    chk("arst.divBusy", b8.divBusy, 1'b0);
    set_in(1, 5'd9, 1, 5'd0, 0, 5'd1, 1, 0);
    step();
    Reset_n = 1'b1;
    set_in(1, 5'd9, 1, 5'd9, 1, 5'd1, 1, 0);
    #1;
    chk("arst.post.stall",    b8.stall,    1'b0);
    chk("arst.post.muxSrc1",  b8.muxSrc1,  1'b0);
    chk("arst.post.mux2Src1", b8.mux2Src1, 1'b0);
    step();

    // Randomized traffic over a small register set to provoke frequent matches.
    for (int n = 0; n < 600; n++) begin
      set_in(logic'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 7) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
